vga_frame_arbiter: RTL and testbench

Schedules SDRAM burst traffic between the camera write path and the VGA read path in the OV5640→SDRAM→VGA pipeline. It watches the camera write FIFO level and the VGA FIFO refill request, arbitrates the single SDRAM command port between them, and generates burst addresses. It also manages a two-buffer (ping-pong) frame store so the display always reads a completely written frame.

---
 rtl/vga_frame_arbiter.sv | 175 +++++++++++++++++
 tb/tb_vga_frame_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_arbiter.sv
// vga_frame_arbiter
// Arbitrates the single SDRAM burst command port between the camera write
// path and the VGA read path, generates burst start addresses and manages a
// ping-pong frame store so the display only ever reads a completed frame.
//
// Ports:
//   clk, rst_n          clock, synchronous active-high reset (asserted = 1)
//   init_done           SDRAM initialised; no command is issued while 0
//   wr_req              camera FIFO holds at least one burst
//   wr_frame_start      camera vsync pulse
//   rd_req              VGA FIFO refill request (level)
//   rd_frame_start      VGA vsync pulse
//   cmd_valid/cmd_write/cmd_bank/cmd_addr/cmd_len   burst command
//   cmd_ack             command accepted
//   cmd_done            burst data phase finished (pulse)
//   wbuf, rbuf          buffer currently written / read
//   busy                arbiter not idle
module vga_frame_arbiter #(
   parameter int unsigned BURST_LEN   = 256,
   parameter int unsigned FRAME_WORDS = 307200,
   parameter int unsigned ADDR_W      = 22
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_done,
   input  logic              wr_req,
   input  logic              wr_frame_start,
   input  logic              rd_req,
   input  logic              rd_frame_start,
   output logic              cmd_valid,
   output logic              cmd_write,
   output logic [1:0]        cmd_bank,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [8:0]        cmd_len,
   input  logic              cmd_ack,
   input  logic              cmd_done,
   output logic              wbuf,
   output logic              rbuf,
   output logic              busy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
   localparam logic [ADDR_W-1:0] FRAME_END  = ADDR_W'(FRAME_WORDS);

   logic [1:0]        state;
   logic              last_grant;  // 1 = last grant was a write
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic              wr_full, done_buf, done_valid, wr_pend, rd_pend;

   logic [ADDR_W-1:0] wr_ptr_n, rd_ptr_n;
   logic              wr_full_n, done_buf_n, done_valid_n, wr_pend_n, rd_pend_n;
   logic              wbuf_n, rbuf_n;
   logic              done_evt, apply_wr, apply_rd, wr_grantable, start, grant_w;

   assign cmd_len = 9'(BURST_LEN);
   assign busy    = (state != IDLE);

   always_comb begin
      done_evt = (state == WAIT) && cmd_done;
      // Frame starts act at once in IDLE; otherwise they wait for the burst end.
      apply_rd = ((state == IDLE) && rd_frame_start) ||
                 (done_evt && (rd_pend || rd_frame_start));
      apply_wr = ((state == IDLE) && wr_frame_start) ||
                 (done_evt && (wr_pend || wr_frame_start));

      wr_pend_n = 1'b0;
      rd_pend_n = 1'b0;
      if ((state != IDLE) && !done_evt) begin
         wr_pend_n = wr_pend || wr_frame_start;
         rd_pend_n = rd_pend || rd_frame_start;
      end

      wr_ptr_n     = wr_ptr;
      rd_ptr_n     = rd_ptr;
      wr_full_n    = wr_full;
      done_buf_n   = done_buf;
      done_valid_n = done_valid;
      wbuf_n       = wbuf;
      rbuf_n       = rbuf;

      // Pointer advance; dropped when the same side's frame restarts.
      if (done_evt && cmd_write && !apply_wr) begin
         wr_ptr_n = wr_ptr + BURST_STEP;
         if (wr_ptr_n == FRAME_END) begin
            wr_full_n    = 1'b1;
            done_buf_n   = wbuf;
            done_valid_n = 1'b1;
         end
      end
      if (done_evt && !cmd_write && !apply_rd) begin
         rd_ptr_n = rd_ptr + BURST_STEP;
         if (rd_ptr_n == FRAME_END) begin
            rd_ptr_n = '0;
         end
      end

      // Read side first so a completed write frame never lands on rbuf.
      if (apply_rd) begin
         rd_ptr_n = '0;
         if (done_valid_n) begin
            rbuf_n = done_buf_n;
         end
      end
      if (apply_wr) begin
         wr_ptr_n  = '0;
         wr_full_n = 1'b0;
         if (wr_full) begin
            wbuf_n = ~rbuf_n;
         end
      end

      wr_grantable = wr_req && !wr_full_n;
      start        = (state == IDLE) && init_done && (wr_grantable || rd_req);
      grant_w      = wr_grantable && (!rd_req || !last_grant);
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         wr_full    <= 1'b0;
         done_buf   <= 1'b0;
         done_valid <= 1'b0;
         wr_pend    <= 1'b0;
         rd_pend    <= 1'b0;
         wbuf       <= 1'b0;
         rbuf       <= 1'b0;
         cmd_valid  <= 1'b0;
         cmd_write  <= 1'b0;
         cmd_bank   <= 2'b00;
         cmd_addr   <= '0;
      end else begin
         wr_ptr     <= wr_ptr_n;
         rd_ptr     <= rd_ptr_n;
         wr_full    <= wr_full_n;
         done_buf   <= done_buf_n;
         done_valid <= done_valid_n;
         wr_pend    <= wr_pend_n;
         rd_pend    <= rd_pend_n;
         wbuf       <= wbuf_n;
         rbuf       <= rbuf_n;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= ISSUE;
                  cmd_valid  <= 1'b1;
                  cmd_write  <= grant_w;
                  cmd_bank   <= {1'b0, grant_w ? wbuf_n : rbuf_n};
                  cmd_addr   <= grant_w ? wr_ptr_n : rd_ptr_n;
                  last_grant <= grant_w;
               end
            end
            ISSUE: begin
               if (cmd_ack) begin
                  cmd_valid <= 1'b0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (cmd_done) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_frame_arbiter.sv
module tb_vga_frame_arbiter;

   localparam int BL = 256;
   localparam int FW = 307200;

   logic        clk = 1'b0;
   logic        rst_n, init_done, wr_req, wr_frame_start, rd_req, rd_frame_start;
   logic        cmd_ack, cmd_done;
   logic        cmd_valid, cmd_write, wbuf, rbuf, busy;
   logic [1:0]  cmd_bank;
   logic [21:0] cmd_addr;
   logic [8:0]  cmd_len;

   int checks = 0;
   int failures = 0;

   // Reference model of the frame store, in plain arithmetic.
   int m_wr_ptr, m_rd_ptr;
   bit m_wr_full, m_wbuf, m_rbuf, m_done_buf, m_done_valid, m_last_w;

   always #5 clk = ~clk;

   vga_frame_arbiter dut (
      .clk(clk), .rst_n(rst_n), .init_done(init_done),
      .wr_req(wr_req), .wr_frame_start(wr_frame_start),
      .rd_req(rd_req), .rd_frame_start(rd_frame_start),
      .cmd_valid(cmd_valid), .cmd_write(cmd_write), .cmd_bank(cmd_bank),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_ack(cmd_ack), .cmd_done(cmd_done),
      .wbuf(wbuf), .rbuf(rbuf), .busy(busy)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_reset();
      m_wr_ptr = 0; m_rd_ptr = 0; m_wr_full = 0; m_wbuf = 0; m_rbuf = 0;
      m_done_buf = 0; m_done_valid = 0; m_last_w = 1;
   endtask

   task automatic model_fs(input bit fs_w, input bit fs_r);
      if (fs_r) begin
         m_rd_ptr = 0;
         if (m_done_valid) m_rbuf = m_done_buf;
      end
      if (fs_w) begin
         if (m_wr_full) m_wbuf = ~m_rbuf;
         m_wr_ptr = 0;
         m_wr_full = 0;
      end
   endtask

   task automatic model_done(input bit is_w, input bit fs_w, input bit fs_r);
      if (is_w && !fs_w) begin
         m_wr_ptr += BL;
         if (m_wr_ptr == FW) begin
            m_wr_full = 1; m_done_buf = m_wbuf; m_done_valid = 1;
         end
      end
      if (!is_w && !fs_r) m_rd_ptr = (m_rd_ptr + BL) % FW;
      model_fs(fs_w, fs_r);
   endtask

   // Returns 1 for write, 0 for read, -1 for no grant.
   function automatic int exp_grant(input bit w, input bit r);
      bit ew = w && !m_wr_full;
      if (ew && r) return m_last_w ? 0 : 1;
      if (ew) return 1;
      if (r) return 0;
      return -1;
   endfunction

   task automatic do_reset();
      rst_n = 1; wr_req = 0; rd_req = 0; wr_frame_start = 0; rd_frame_start = 0;
      cmd_ack = 0; cmd_done = 0;
      tick(3);
      rst_n = 0;
      model_reset();
      tick(1);
   endtask

   task automatic pulse_fs(input bit fs_w, input bit fs_r);
      wr_frame_start = fs_w; rd_frame_start = fs_r;
      tick(1);
      wr_frame_start = 0; rd_frame_start = 0;
      model_fs(fs_w, fs_r);
   endtask

   // Presents requests, handshakes one burst, optionally pulses frame starts during WAIT.
   task automatic run_burst(input bit w, input bit r, input bit fs_w, input bit fs_r,
                            output bit got, output bit ow, output logic [1:0] ob,
                            output logic [21:0] oa, output bit obusy);
      got = 0; ow = 0; ob = 0; oa = 0; obusy = 0;
      wr_req = w; rd_req = r;
      for (int i = 0; i < 20 && !got; i++) begin
         tick(1);
         if (cmd_valid) got = 1;
      end
      wr_req = 0; rd_req = 0;
      if (!got) return;
      ow = cmd_write; ob = cmd_bank; oa = cmd_addr; obusy = busy;
      tick($urandom_range(0, 2));
      cmd_ack = 1;
      tick(1);
      cmd_ack = 0;
      tick($urandom_range(0, 2));
      if (fs_w || fs_r) begin
         wr_frame_start = fs_w; rd_frame_start = fs_r;
         tick(1);
         wr_frame_start = 0; rd_frame_start = 0;
      end
      cmd_done = 1;
      tick(1);
      cmd_done = 0;
   endtask

   task automatic test_reset();
      bit got, ow, obusy; logic [1:0] ob; logic [21:0] oa; bit seen = 0;
      init_done = 0;
      do_reset();
      checks++;
      if ({cmd_valid, cmd_write, cmd_bank, cmd_addr, wbuf, rbuf, busy} !== 29'd0 ||
          cmd_len !== 9'd256) begin
         failures++;
         $display("FAIL reset_state: valid=%0b wr=%0b bank=%0d addr=%0d len=%0d wbuf=%0b rbuf=%0b busy=%0b, want all 0 and len 256",
                  cmd_valid, cmd_write, cmd_bank, cmd_addr, cmd_len, wbuf, rbuf, busy);
      end
      rd_req = 1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (cmd_valid || busy) seen = 1;
      end
      rd_req = 0;
      checks++;
      if (seen) begin
         failures++;
         $display("FAIL no_cmd_before_init: saw command while init_done=0, want none");
      end
      init_done = 1;
      run_burst(0, 1, 0, 0, got, ow, ob, oa, obusy);
      checks++;
      if (!got || ow !== 0 || ob !== 2'd0 || oa !== 22'd0 || obusy !== 1 || cmd_len !== 9'd256) begin
         failures++;
         $display("FAIL first_read: got=%0b w=%0b bank=%0d addr=%0d busy=%0b, want 1 0 0 0 1",
                  got, ow, ob, oa, obusy);
      end
      model_done(0, 0, 0); m_last_w = 0;
   endtask

   task automatic test_round_robin();
      bit got, ow, obusy; logic [1:0] ob; logic [21:0] oa;
      bit exp_w [4] = '{0, 1, 0, 1};
      int exp_a [4] = '{0, 0, 256, 256};
      do_reset();
      for (int i = 0; i < 4; i++) begin
         run_burst(1, 1, 0, 0, got, ow, ob, oa, obusy);
         checks++;
         if (!got || ow !== exp_w[i] || oa !== 22'(exp_a[i])) begin
            failures++;
            $display("FAIL round_robin[%0d]: got=%0b w=%0b addr=%0d, want w=%0b addr=%0d",
                     i, got, ow, oa, exp_w[i], exp_a[i]);
         end
         m_last_w = exp_w[i];
         model_done(exp_w[i], 0, 0);
      end
   endtask

   task automatic test_random();
      bit got, ow, obusy; logic [1:0] ob; logic [21:0] oa;
      bit w, r, fw, fr; int eg; logic [1:0] eb; int ea;
      do_reset();
      for (int i = 0; i < 80; i++) begin
         w = 1'($urandom); r = 1'($urandom);
         if (!w && !r) r = 1;
         fw = ($urandom_range(0, 7) == 0); fr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 9) == 0) pulse_fs(1'($urandom), 1'($urandom));
         eg = exp_grant(w, r);
         eb = {1'b0, (eg == 1) ? m_wbuf : m_rbuf};
         ea = (eg == 1) ? m_wr_ptr : m_rd_ptr;
         run_burst(w, r, fw, fr, got, ow, ob, oa, obusy);
         checks++;
         if (!got || ow !== 1'(eg) || ob !== eb || oa !== 22'(ea)) begin
            failures++;
            $display("FAIL random[%0d]: got=%0b w=%0b bank=%0d addr=%0d, want w=%0d bank=%0d addr=%0d",
                     i, got, ow, ob, oa, eg, eb, ea);
         end
         m_last_w = (eg == 1);
         model_done(eg == 1, fw, fr);
      end
      checks++;
      if (wbuf !== m_wbuf || rbuf !== m_rbuf) begin
         failures++;
         $display("FAIL random_bufs: wbuf=%0b rbuf=%0b, want %0b %0b", wbuf, rbuf, m_wbuf, m_rbuf);
      end
   endtask

   task automatic test_frame_fill();
      bit got, ow, obusy; logic [1:0] ob; logic [21:0] oa; int bad;
      do_reset();
      for (int f = 0; f < 2; f++) begin
         bad = 0;
         for (int i = 0; i < FW / BL; i++) begin
            run_burst(1, 0, 0, 0, got, ow, ob, oa, obusy);
            if (!got || ow !== 1 || oa !== 22'(m_wr_ptr) || ob !== {1'b0, m_wbuf}) bad++;
            m_last_w = 1;
            model_done(1, 0, 0);
         end
         checks++;
         if (bad != 0) begin
            failures++;
            $display("FAIL fill[%0d]: %0d bad write bursts, want 0", f, bad);
         end
         run_burst(1, 0, 0, 0, got, ow, ob, oa, obusy);
         checks++;
         if (got) begin
            failures++;
            $display("FAIL full_blocks_write[%0d]: write issued at addr %0d, want none", f, oa);
            cmd_ack = 1; tick(1); cmd_ack = 0; cmd_done = 1; tick(1); cmd_done = 0;
         end
         if (f == 0) begin
            pulse_fs(0, 1);
            checks++;
            if (rbuf !== 1'b0) begin
               failures++;
               $display("FAIL rbuf_after_frame: rbuf=%0b, want 0", rbuf);
            end
            pulse_fs(1, 0);
            checks++;
            if (wbuf !== 1'b1) begin
               failures++;
               $display("FAIL wbuf_after_frame: wbuf=%0b, want 1", wbuf);
            end
         end
      end
      // Second frame went to buffer 1; both vsyncs together.
      pulse_fs(1, 1);
      checks++;
      if (rbuf !== 1'b1 || wbuf !== 1'b0 || rbuf !== m_rbuf || wbuf !== m_wbuf) begin
         failures++;
         $display("FAIL simultaneous_start: rbuf=%0b wbuf=%0b, want 1 0", rbuf, wbuf);
      end
   endtask

   task automatic test_read_wrap();
      bit got, ow, obusy; logic [1:0] ob; logic [21:0] oa; int bad = 0;
      do_reset();
      for (int i = 0; i <= FW / BL; i++) begin
         run_burst(0, 1, 0, 0, got, ow, ob, oa, obusy);
         if (!got || ow !== 0 || oa !== 22'(m_rd_ptr)) bad++;
         if (i == FW / BL) begin
            checks++;
            if (!got || oa !== 22'd0) begin
               failures++;
               $display("FAIL read_wrap: burst 1201 addr=%0d got=%0b, want 0", oa, got);
            end
         end
         model_done(0, 0, 0);
      end
      checks++;
      if (bad != 0) begin
         failures++;
         $display("FAIL read_seq: %0d bad read bursts, want 0", bad);
      end
   endtask

   task automatic test_pending_start();
      bit got, ow, obusy; logic [1:0] ob; logic [21:0] oa;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         run_burst(0, 1, 0, 0, got, ow, ob, oa, obusy);
         model_done(0, 0, 0);
      end
      run_burst(0, 1, 0, 1, got, ow, ob, oa, obusy);
      checks++;
      if (!got || oa !== 22'd512) begin
         failures++;
         $display("FAIL pending_rd_inflight: addr=%0d got=%0b, want 512", oa, got);
      end
      run_burst(0, 1, 0, 0, got, ow, ob, oa, obusy);
      checks++;
      if (!got || oa !== 22'd0) begin
         failures++;
         $display("FAIL pending_rd_next: addr=%0d got=%0b, want 0", oa, got);
      end
      run_burst(1, 0, 0, 0, got, ow, ob, oa, obusy);
      run_burst(1, 0, 1, 0, got, ow, ob, oa, obusy);
      run_burst(1, 0, 0, 0, got, ow, ob, oa, obusy);
      checks++;
      if (!got || ow !== 1 || oa !== 22'd0) begin
         failures++;
         $display("FAIL pending_wr_next: w=%0b addr=%0d got=%0b, want 1 0", ow, oa, got);
      end
   endtask

   task automatic test_reset_midburst();
      bit got, ow, obusy; logic [1:0] ob; logic [21:0] oa;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         run_burst(0, 1, 0, 0, got, ow, ob, oa, obusy);
      end
      rd_req = 1;
      tick(3);
      rd_req = 0;
      cmd_ack = 1; tick(1); cmd_ack = 0;
      rst_n = 1; tick(1); rst_n = 0;
      checks++;
      if (busy !== 0 || cmd_valid !== 0 || cmd_addr !== 22'd0) begin
         failures++;
         $display("FAIL reset_midburst: busy=%0b valid=%0b addr=%0d, want 0 0 0", busy, cmd_valid, cmd_addr);
      end
      cmd_done = 1; cmd_ack = 1; tick(1); cmd_done = 0; cmd_ack = 0;
      tick(2);
      checks++;
      if (busy !== 0 || cmd_valid !== 0) begin
         failures++;
         $display("FAIL late_pulses_ignored: busy=%0b valid=%0b, want 0 0", busy, cmd_valid);
      end
      run_burst(0, 1, 0, 0, got, ow, ob, oa, obusy);
      checks++;
      if (!got || oa !== 22'd0) begin
         failures++;
         $display("FAIL read_after_reset: addr=%0d got=%0b, want 0", oa, got);
      end
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_random();
      test_pending_start();
      test_reset_midburst();
      test_read_wrap();
      test_frame_fill();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
